// File: rtl/full_handshake_rx_fifo.sv
// Receive side of a four-phase req/ack clock-domain crossing.
// Synchronised requests push TX data into a first-word-fall-through FIFO drained over valid/ready.
module full_handshake_rx_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] req_data_i,
    output logic          ack_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic          req_s1;
    logic          req_s;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [DW-1:0] mem [DEPTH];

    // Only req_s may be used downstream; req_data_i is trusted stable once req_s is seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s  <= 1'b0;
        end else begin
            req_s1 <= req_i;
            req_s  <= req_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_s && (count < FULL_COUNT)) state_next = ACK;
            ACK:  if (!req_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ack_o is the state flop itself, so it cannot glitch toward the TX domain.
    always_comb begin
        ack_o = (state == ACK);
        push  = (state == IDLE) && req_s && (count < FULL_COUNT);
    end

    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
    assign count_o = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_data_i;
        end
    end

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_full_handshake_rx_fifo.sv
// Directed self-checking bench for full_handshake_rx_fifo, acting as the TX side of the handshake.
module tb_full_handshake_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic [31:0] req_data_i;
    logic        ack_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  count_o;

    int testsRun  = 0;
    int failCount = 0;

    logic        monEn = 1'b0;
    logic [31:0] seen [$];

    full_handshake_rx_fifo #(.DW(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .ack_o      (ack_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    // Record every word the consumer accepts, sampled mid-cycle before its pop edge.
    always @(negedge clk) begin
        if (monEn && rst_n && valid_o && ready_i) seen.push_back(data_o);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic popOne();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic waitAck(input logic level, input string tag);
        for (int i = 0; i < 20 && ack_o !== level; i++) tick();
        checkOutput(tag, {31'd0, ack_o}, {31'd0, level});
    endtask

    // Complete four-phase transfer as the TX block would perform it.
    task automatic applyStimulus(input logic [31:0] value);
        req_data_i = value;
        req_i      = 1'b1;
        waitAck(1'b1, "xfer ack rise");
        req_i = 1'b0;
        waitAck(1'b0, "xfer ack fall");
    endtask

    initial begin
        rst_n      = 1'b0;
        req_i      = 1'b1;
        req_data_i = 32'h0;
        ready_i    = 1'b0;

        // Reset held with a request pending
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("reset ack", {31'd0, ack_o}, 32'd0);
            checkOutput("reset valid", {31'd0, valid_o}, 32'd0);
            checkOutput("reset count", {29'd0, count_o}, 32'd0);
            checkOutput("reset data", data_o, 32'd0);
        end
        req_i = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        // Single transfer latency
        req_data_i = 32'hDEADBEEF;
        req_i      = 1'b1;
        tick();
        tick();
        checkOutput("single ack clk2", {31'd0, ack_o}, 32'd0);
        tick();
        checkOutput("single ack clk3", {31'd0, ack_o}, 32'd1);
        checkOutput("single count clk3", {29'd0, count_o}, 32'd1);
        checkOutput("single valid clk3", {31'd0, valid_o}, 32'd1);
        tick();
        checkOutput("single valid clk4", {31'd0, valid_o}, 32'd1);
        checkOutput("single data clk4", data_o, 32'hDEADBEEF);
        checkOutput("single count clk4", {29'd0, count_o}, 32'd1);
        req_i = 1'b0;
        tick();
        tick();
        checkOutput("single ack fall clk2", {31'd0, ack_o}, 32'd1);
        tick();
        checkOutput("single ack fall clk3", {31'd0, ack_o}, 32'd0);
        popOne();
        checkOutput("single drained count", {29'd0, count_o}, 32'd0);
        checkOutput("single drained data", data_o, 32'd0);

        // Fill to full, then backpressure on the fifth request
        for (int v = 1; v <= 4; v++) applyStimulus(32'(v));
        checkOutput("full count", {29'd0, count_o}, 32'd4);
        req_data_i = 32'd5;
        req_i      = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("full no ack", {31'd0, ack_o}, 32'd0);
        checkOutput("full count hold", {29'd0, count_o}, 32'd4);
        checkOutput("full head", data_o, 32'd1);
        popOne();
        checkOutput("full pop ack", {31'd0, ack_o}, 32'd0);
        checkOutput("full pop count", {29'd0, count_o}, 32'd3);
        checkOutput("full pop head", data_o, 32'd2);
        tick();
        checkOutput("full fifth ack", {31'd0, ack_o}, 32'd1);
        checkOutput("full refill count", {29'd0, count_o}, 32'd4);
        req_i = 1'b0;
        waitAck(1'b0, "full fifth ack fall");
        for (int v = 2; v <= 5; v++) begin
            checkOutput("full drain order", data_o, 32'(v));
            popOne();
        end
        checkOutput("full drained valid", {31'd0, valid_o}, 32'd0);

        // Push and pop on the same edge
        applyStimulus(32'h0000_00B1);
        applyStimulus(32'h0000_00B2);
        checkOutput("pushpop pre count", {29'd0, count_o}, 32'd2);
        req_data_i = 32'h0000_00B3;
        req_i      = 1'b1;
        tick();
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        checkOutput("pushpop ack", {31'd0, ack_o}, 32'd1);
        checkOutput("pushpop count", {29'd0, count_o}, 32'd2);
        checkOutput("pushpop head", data_o, 32'h0000_00B2);
        req_i = 1'b0;
        waitAck(1'b0, "pushpop ack fall");
        popOne();
        checkOutput("pushpop order", data_o, 32'h0000_00B3);
        popOne();
        checkOutput("pushpop empty", {29'd0, count_o}, 32'd0);

        // Wrap-around streaming with the consumer always ready
        seen.delete();
        monEn   = 1'b1;
        ready_i = 1'b1;
        for (int v = 0; v < 10; v++) applyStimulus(32'hA0 + 32'(v));
        tick();
        tick();
        monEn   = 1'b0;
        ready_i = 1'b0;
        checkOutput("wrap word count", 32'(seen.size()), 32'd10);
        for (int v = 0; v < 10 && v < seen.size(); v++) begin
            checkOutput("wrap order", seen[v], 32'hA0 + 32'(v));
        end
        checkOutput("wrap empty", {29'd0, count_o}, 32'd0);

        // Reset while acknowledging with a partly filled FIFO
        applyStimulus(32'h61);
        applyStimulus(32'h62);
        req_data_i = 32'h63;
        req_i      = 1'b1;
        waitAck(1'b1, "rstack ack rise");
        checkOutput("rstack pre count", {29'd0, count_o}, 32'd3);
        rst_n = 1'b0;
        tick();
        checkOutput("rstack ack", {31'd0, ack_o}, 32'd0);
        checkOutput("rstack count", {29'd0, count_o}, 32'd0);
        checkOutput("rstack valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rstack data", data_o, 32'd0);
        req_i = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
